// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and the shifter's state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_SHW   = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/right_shift_stage.sv
// One time-shared right-shift level: shifts by 2**stage with fill bits when enabled.
module right_shift_stage #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int CW    = (SHW > 1) ? $clog2(SHW) : 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             fill,
  input  logic [CW-1:0]    stage,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] cand [SHW];

  for (genvar s = 0; s < SHW; s++) begin : g_cand
    assign cand[s] = {{(2**s){fill}}, data[WIDTH-1:2**s]};
  end

  // NOTE: result gets a default before the mux so no path leaves it unassigned (no latch).
  always_comb begin
    result = data;
    if (en) begin
      for (int i = 0; i < SHW; i++) begin
        if (stage == CW'(i)) result = cand[i];
      end
    end
  end

endmodule

// File: rtl/right_shift_unit.sv
// Multi-cycle right shifter: resolves one power-of-two distance per clock through a
// single shared stage, with valid/ready handshakes on both sides.
module right_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = ALU_SHW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CW = (SHW > 1) ? $clog2(SHW) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] data_r;
  logic [SHW-1:0]   shamt_r;
  logic             fill_r;
  logic [WIDTH-1:0] stage_result;

  right_shift_stage #(
    .WIDTH(WIDTH),
    .SHW  (SHW),
    .CW   (CW)
  ) u_stage (
    .data  (data_r),
    .en    (shamt_r[cnt]),
    .fill  (fill_r),
    .stage (cnt),
    .result(stage_result)
  );

  // The data register is the output register, so it is cleared to give out_data=0 after reset.
  assign out_data = data_r;

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      data_r    <= '0;
      shamt_r   <= '0;
      fill_r    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            data_r   <= in_data;
            shamt_r  <= in_shamt;
            fill_r   <= in_arith & in_data[WIDTH-1];
            cnt      <= '0;
            state    <= S_SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_SHIFT: begin
          data_r <= stage_result;
          cnt    <= cnt + CW'(1);
          // Always run every stage, even for shamt=0, so latency is fixed.
          if (cnt == CW'(SHW - 1)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_right_shift_unit.sv
// Self-checking bench for right_shift_unit: directed vectors, backpressure, reset abort
// and back-to-back random traffic against a cycle-level behavioural model.
module tb_right_shift_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  right_shift_unit dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_arith (in_arith),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted operand is unavailable for 5 cycles, then the
  // reference result is offered until taken.
  bit          m_idle = 1'b1;
  int          m_wait = 0;
  bit          m_done = 1'b0;
  bit          m_zero = 1'b1;
  logic [31:0] m_result = '0;
  int          cyc = 0;
  int          last_accept = -1;
  int          n_results = 0;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                            input logic a);
    logic signed [31:0] sd;
    sd = d;
    return a ? 32'(sd >>> sh) : (d >> sh);
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_idle = 1'b1;
      m_wait = 0;
      m_done = 1'b0;
      m_zero = 1'b1;
      last_accept = -1;
    end else if (m_idle) begin
      if (in_valid) begin
        m_result = ref_shift(in_data, in_shamt, in_arith);
        m_idle = 1'b0;
        m_zero = 1'b0;
        m_wait = 5;
        if (last_accept >= 0) check("issue_interval_ge_7", 32'(cyc - last_accept >= 7), 32'd1);
        last_accept = cyc;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_done = 1'b1;
    end else if (out_ready) begin
      m_done = 1'b0;
      m_idle = 1'b1;
      n_results++;
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clock) begin
    if (cmp_en) begin
      check("in_ready", 32'(in_ready), 32'(m_idle));
      check("out_valid", 32'(out_valid), 32'(m_done));
      check("busy", 32'(busy), 32'(!m_idle));
      check("valid_ready_exclusive", 32'(in_ready & out_valid), 32'd0);
      if (m_done) check("out_data", out_data, m_result);
      if (m_zero) check("out_data_after_reset", out_data, 32'd0);
    end
  end

  task automatic do_op(input string name, input logic [31:0] d, input logic [4:0] sh,
                       input logic a, input logic [31:0] exp, input int hold);
    int n;
    int lat;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_arith = a;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) check({name, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clock);
    @(negedge clock);
    // Scramble inputs after the handshake; the captured operand must not change.
    in_valid = 1'b0;
    in_data  = ~d;
    in_shamt = ~sh;
    in_arith = ~a;
    check({name, "_model_pin"}, m_result, exp);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd5);
    check({name, "_data"}, out_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check({name, "_hold_data"}, out_data, exp);
      check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check({name, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    check({name, "_idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_arith  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    cmp_en = 1'b1;

    do_op("lsr_f0", 32'hF0F0_F0F0, 5'd4, 1'b0, 32'h0F0F_0F0F, 0);
    do_op("asr_f0", 32'hF0F0_F0F0, 5'd4, 1'b1, 32'hFF0F_0F0F, 10);
    do_op("asr_min31", 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 0);
    do_op("lsr_min31", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 0);
    do_op("asr_max31", 32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000, 0);
    do_op("shamt0", 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678, 0);
    do_op("all_stages", 32'hDEAD_BEEF, 5'd31, 1'b0, 32'h0000_0001, 2);

    // Abort an operation with reset two cycles after its handshake.
    in_valid = 1'b1;
    in_data  = 32'hCAFE_F00D;
    in_shamt = 5'd3;
    in_arith = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data", out_data, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("abort_no_result", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    do_op("after_abort", 32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001, 0);

    // Back-to-back random traffic with both sides always willing.
    begin
      int start_results;
      start_results = n_results;
      out_ready = 1'b1;
      for (int i = 0; i < 420; i++) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        in_shamt = 5'($urandom_range(0, 31));
        in_arith = 1'($urandom_range(0, 1));
        @(negedge clock);
      end
      in_valid = 1'b0;
      repeat (10) @(negedge clock);
      check("random_result_count", 32'(n_results - start_results >= 55), 32'd1);
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/right_shift_unit.md
Name: right_shift_unit

Overview:
- Multi-cycle 32-bit right shifter for the ALU; the right-shift counterpart to the existing combinational left logical shifter.
- Supports logical (zero-fill) and arithmetic (sign-fill) right shift by 0–31.
- Resolves one power-of-two stage per clock (distances 1, 2, 4, 8, 16), so the mux tree is time-shared.
- Valid/ready handshakes on both input and output, so the ALU control can stall or backpressure it.

Parameters:
- WIDTH, 32, data width; must be a power of two.
- SHW, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand presented
- in_ready  out  1  unit can accept an operand (IDLE only)
- in_data  in  WIDTH  value to shift
- in_shamt  in  SHW  shift amount, unsigned
- in_arith  in  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  shifted result
- busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset: synchronous, active-high, one clock, priority over everything.
  - Forces IDLE, stage counter 0, data register 0.
  - in_ready=1, out_valid=0, out_data=0, busy=0.
  - Reset mid-operation discards the in-flight operand; no result is produced.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready at an edge:
    - load data_r<=in_data, shamt_r<=in_shamt;
    - fill_r<=in_arith & in_data[WIDTH-1];
    - cnt<=0; go to SHIFT.
  - SHIFT: in_ready=0, busy=1. Each edge applies stage cnt:
    - if shamt_r[cnt]=1, data_r<={ {2^cnt{fill_r}}, data_r[WIDTH-1:2^cnt] };
    - otherwise data_r is unchanged.
    - cnt increments each edge. The edge that applies cnt=SHW-1 moves to DONE.
  - DONE: out_valid=1, out_data=data_r, busy=1. Result stays stable while out_ready=0.
    - On out_ready=1 at an edge: go to IDLE, out_valid<=0.
- Latency: always exactly SHW shift edges, including shamt=0.
  - out_valid rises SHW (5) cycles after the input handshake edge.
  - No early completion.
- Throughput:
  - in_ready is 0 in DONE, so a new operand cannot be accepted on the same edge a result is consumed.
  - Minimum issue interval is SHW+2 = 7 cycles.
- out_data: registered. Holds data_r in every state, so it is only meaningful while out_valid=1.
- Sign capture: fill_r is captured at load time; later in_data changes have no effect.
- Inputs: in_shamt and in_arith are ignored when there is no handshake.
- Invariant: out_valid and in_ready are never both 1.
- X-safety: in_data is not sampled in any state other than IDLE.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_WIDTH=32, ALU_SHW=5;
  - state encoding S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
  - No other typedefs are needed.
- Sub-module right_shift_stage (combinational): one level of right shift.
  - Inputs: data, en, fill, stage index; output: result.
  - Instantiated once. The stage distance is selected by cnt via a 5-way mux over distances 1/2/4/8/16.
  - It is not replicated five times; that would negate the area saving.

Test Plan:
- Logical shift: in_data=0xF0F0F0F0, shamt=4, arith=0 -> out_data=0x0F0F0F0F; out_valid rises 5 cycles after accept. Repeat with arith=1 -> 0xFF0F0F0F.
- Sign extremes: 0x80000000, shamt=31, arith=1 -> 0xFFFFFFFF; arith=0 -> 0x00000001. Also 0x7FFFFFFF, shamt=31, arith=1 -> 0x00000000.
- Zero and all-stages: 0x12345678, shamt=0 -> 0x12345678 with the full 5-cycle latency. Then 0xDEADBEEF, shamt=31 (all stages active), arith=0 -> 0x00000001.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. out_data and out_valid stay stable and in_ready stays 0. On out_ready=1, IDLE is reached next cycle and in_ready=1.
- Reset mid-operation: assert reset 2 cycles after accept. Next cycle in_ready=1, out_valid=0, out_data=0, busy=0, and no result ever appears. A following operation (0x00000100 >> 8 logical) returns 0x00000001.
- Randomised: back-to-back operations with in_valid held high. Results match a reference (logical >> and signed >>>), and the issue interval is never below 7 cycles.
